fifo_disp_formatter: RTL

//  Upstream feeder for the 8-digit multiplexed 7-seg driver. Periodically snapshots FIFO

---
 rtl/disp_pkg.sv | 37 +++
 rtl/bin2bcd_seq.sv | 50 +++++
 rtl/fifo_disp_formatter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared constants, state encodings and field formatter for the FIFO status display path.
// Latency: none (package only).
// Backpressure: none (package only).
package disp_pkg;

    // Widest binary value the conversion engine accepts (max 511)
    localparam int BCD_W = 9;

    // Character codes understood by the 7-seg scanner
    localparam logic [5:0] CH_BLANK = 6'd63;
    localparam logic [5:0] CH_E     = 6'd14;
    localparam logic [5:0] CH_F     = 6'd15;

    // Frame sequencer states
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LOAD     = 3'd1;
    localparam logic [2:0] ST_CONV_CNT = 3'd2;
    localparam logic [2:0] ST_CONV_DAT = 3'd3;
    localparam logic [2:0] ST_COMMIT   = 3'd4;

    // One 3-digit decimal field as displayed: hundreds, tens, units
    typedef struct packed {
        logic [5:0] hun;
        logic [5:0] ten;
        logic [5:0] uni;
    } field_t;

    // Leading-zero suppression; the units digit is always shown
    function automatic field_t fmt_field(input logic [11:0] bcd);
        field_t f;
        f.hun = (bcd[11:8] == 4'd0) ? CH_BLANK : {2'b00, bcd[11:8]};
        f.ten = (bcd[11:8] == 4'd0 && bcd[7:4] == 4'd0) ? CH_BLANK : {2'b00, bcd[7:4]};
        f.uni = {2'b00, bcd[3:0]};
        return f;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 9-bit binary to three BCD digits.
// Latency: start cycle, then 9 shift cycles; done pulses on the 10th cycle after start.
// Backpressure: none; a new start restarts the engine and bcd holds until then.
module bin2bcd_seq
    import disp_pkg::*;
(
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BCD_W-1:0] bin,
    output logic             done,
    output logic [11:0]      bcd
);

    logic [BCD_W-1:0] bin_sh;
    logic [3:0]       step_cnt;
    logic [11:0]      bcd_adj;

    // Add 3 to every digit that would overflow past 9 when doubled
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    // Load on start, then shift one binary bit into the BCD accumulator per cycle
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            bin_sh   <= '0;
            bcd      <= '0;
            step_cnt <= '0;
            done     <= 1'b0;
        end else if (start) begin
            bin_sh   <= bin;
            bcd      <= '0;
            step_cnt <= 4'(BCD_W);
            done     <= 1'b0;
        end else if (step_cnt != 4'd0) begin
            {bcd, bin_sh} <= {bcd_adj, bin_sh} << 1;
            step_cnt      <= step_cnt - 4'd1;
            done          <= (step_cnt == 4'd1);
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_disp_formatter.sv
// Periodically snapshots FIFO status and formats it as eight 7-seg character codes.
// Latency: outputs commit 22 cycles after the refresh tick; busy is high for 21 of them.
// Backpressure: none; a refresh tick arriving while a frame is in progress is dropped.
module fifo_disp_formatter
    import disp_pkg::*;
#(
    parameter int CNT_W       = 5,
    parameter int DATA_W      = 8,
    parameter int REFRESH_DIV = 100000
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic [CNT_W-1:0]  fifo_count,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              fifo_full,
    input  logic              fifo_empty,
    output logic [5:0]        out7,
    output logic [5:0]        out6,
    output logic [5:0]        out5,
    output logic [5:0]        out4,
    output logic [5:0]        out3,
    output logic [5:0]        out2,
    output logic [5:0]        out1,
    output logic [5:0]        out0,
    output logic [2:0]        ndigits,
    output logic              busy
);

    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [DIV_W-1:0] div;
    logic             tick;
    logic [2:0]       state;
    logic [BCD_W-1:0] cnt_ext;
    logic [BCD_W-1:0] dat_ext;
    logic [BCD_W-1:0] snap_dat;
    logic             snap_full;
    logic             snap_empty;
    logic [11:0]      cnt_bcd;
    logic [11:0]      dat_bcd;
    logic             b_start;
    logic [BCD_W-1:0] b_bin;
    logic             b_done;
    logic [11:0]      b_bcd;
    field_t           cnt_fld;
    field_t           dat_fld;

    // The scanner always drives all eight digits
    assign ndigits = 3'd0;

    // Free-running refresh divider; wraps on its own count so tick never feeds back into it
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            div <= '0;
        end else if (div == DIV_W'(REFRESH_DIV - 1)) begin
            div <= '0;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    assign tick = (div == DIV_W'(REFRESH_DIV - 1));

    // Zero-extend the live inputs to the converter width
    always_comb begin
        cnt_ext = '0;
        dat_ext = '0;
        cnt_ext[CNT_W-1:0]  = fifo_count;
        dat_ext[DATA_W-1:0] = fifo_dout;
    end

    // The count is handed to the converter on the same edge as the snapshot, so the
    // converter's input register is the count snapshot; data conversion follows count done.
    always_comb begin
        b_start = (state == ST_LOAD) || ((state == ST_CONV_CNT) && b_done);
        b_bin   = (state == ST_LOAD) ? cnt_ext : snap_dat;
    end

    bin2bcd_seq u_bin2bcd (
        .sys_clk (sys_clk),
        .rst     (rst),
        .start   (b_start),
        .bin     (b_bin),
        .done    (b_done),
        .bcd     (b_bcd)
    );

    // Frame sequencer: snapshot, convert count, convert data, commit
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            snap_dat   <= '0;
            snap_full  <= 1'b0;
            snap_empty <= 1'b0;
            cnt_bcd    <= '0;
            dat_bcd    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (tick) state <= ST_LOAD;
                end
                ST_LOAD: begin
                    snap_dat   <= dat_ext;
                    snap_full  <= fifo_full;
                    snap_empty <= fifo_empty;
                    busy       <= 1'b1;
                    state      <= ST_CONV_CNT;
                end
                ST_CONV_CNT: begin
                    if (b_done) begin
                        cnt_bcd <= b_bcd;
                        state   <= ST_CONV_DAT;
                    end
                end
                ST_CONV_DAT: begin
                    if (b_done) begin
                        dat_bcd <= b_bcd;
                        state   <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign cnt_fld = fmt_field(cnt_bcd);
    assign dat_fld = fmt_field(dat_bcd);

    // All eight character registers update together on commit and hold otherwise
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            {out7, out6, out5, out4, out3, out2, out1, out0} <= {8{CH_BLANK}};
        end else if (state == ST_COMMIT) begin
            out7 <= snap_full ? CH_F : (snap_empty ? CH_E : CH_BLANK);
            out6 <= CH_BLANK;
            out5 <= cnt_fld.hun;
            out4 <= cnt_fld.ten;
            out3 <= cnt_fld.uni;
            out2 <= dat_fld.hun;
            out1 <= dat_fld.ten;
            out0 <= dat_fld.uni;
        end
    end

endmodule
